// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Byte-serial writer that fills the writable instruction memory before the
// processor is released. A framed byte stream is received over a valid/ready
// handshake. Bytes are assembled into DATA_WIDTH-bit instruction words, and
// each word is written with a one-cycle strobe at sequential addresses
// starting at BASE_ADDR. The CPU (program counter) is held in reset until a
// complete, well-formed program has been written.
//
// Frame format: count byte N, then N pairs of (HI, LO), all MSB-first.
//   HI[DATA_WIDTH-9:0] = instr[DATA_WIDTH-1:8]  (unused HI bits must be 0)
//   LO                 = instr[7:0]
//
// Optional build macro: CHECKSUM_EN
//   When defined, one trailing byte is accepted after the last word. It must
//   equal the XOR of the count byte and every HI/LO byte.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   begin a load; sampled only in IDLE, DONE, ERR
//   in_valid  in   in_data holds a byte
//   in_data   in   stream byte [7:0]
//   in_ready  out  loader accepts a byte this cycle
//   wr_en     out  instruction memory write strobe, one cycle per word
//   wr_addr   out  write address [ADDR_WIDTH-1:0]
//   wr_data   out  assembled instruction word [DATA_WIDTH-1:0]
//   cpu_hold  out  program counter reset; 1 = CPU held
//   done      out  level; program loaded successfully
//   error     out  level; framing/range error
// -----------------------------------------------------------------------------
module instruction_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned HI_W = DATA_WIDTH - 8;

  // One past the highest legal address, widened so the range check
  // cannot overflow.
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            remain_q, remain_d;
  logic [HI_W-1:0]       hi_q, hi_d;
  logic [7:0]            lo_q, lo_d;
`ifdef CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic        count_bad;
  logic        hi_bad;
  logic [32:0] load_end;

  assign accept   = in_valid & in_ready;

  // Exclusive end of the requested load region.
  assign load_end  = 33'(BASE_ADDR) + 33'(in_data);
  assign count_bad = (in_data == 8'd0) || (load_end > DEPTH);

  // Any HI bit above the instruction's upper slice is a framing error.
  assign hi_bad    = (in_data >> HI_W) != 8'd0;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= ADDR_WIDTH'(BASE_ADDR);
      remain_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COUNT;
`ifdef CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_COUNT: begin
        if (accept) begin
`ifdef CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (count_bad) begin
            state_d = S_ERR;
          end else begin
            remain_d = in_data;
            addr_d   = ADDR_WIDTH'(BASE_ADDR);
            state_d  = S_HI;
          end
        end
      end

      S_HI: begin
        if (accept) begin
`ifdef CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (hi_bad) begin
            state_d = S_ERR;
          end else begin
            hi_d    = in_data[HI_W-1:0];
            state_d = S_LO;
          end
        end
      end

      S_LO: begin
        if (accept) begin
`ifdef CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          lo_d    = in_data;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        remain_d = remain_q - 8'd1;
        if (remain_q == 8'd1) begin
          // The address is held on the final word so it never steps past
          // the top of memory when the load ends at the last location.
`ifdef CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_HI;
        end
      end

`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_COUNT, S_HI, S_LO: in_ready = 1'b1;
`ifdef CHECKSUM_EN
      S_CSUM:              in_ready = 1'b1;
`endif
      default:             in_ready = 1'b0;
    endcase
  end

  assign wr_en    = (state_q == S_WRITE);
  assign wr_addr  = addr_q;
  assign wr_data  = {hi_q, lo_q};
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

endmodule
